sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//  Serial-in/parallel-out deserializer placed directly downstream of d_ff.
//  - Consumes the registered 1-bit stream dout_q, qualified by a valid strobe.
//  - Assembles WIDTH-bit words, LSB first.
//  - Presents each word on a valid/ready output register.
// PARAMETERS
//  WIDTH   8   data bits per word, >= 2
//  CNT_W   3   bit-counter width, = clog2(WIDTH); checked at elaboration
// PORTS
//  clk         in   1      rising-edge clock
//  n_rst       in   1      async active-low reset
//  din_valid   in   1      din_d carries a valid bit this cycle
//  din_d       in   1      serial data bit (from d_ff dout_q)
//  dout_ready  in   1      consumer accepts dout_data this cycle
//  dout_valid  out  1      dout_data holds an unconsumed word
//  dout_data   out  WIDTH  assembled word, bit0 = first bit received
//  dout_perr   out  1      parity error flag for dout_data (see CONFIGURATION)
//  overrun     out  1      one-cycle pulse: a completed word was dropped
// BEHAVIOUR
//  Reset: one clock; reset asynchronous, active-low.
//   - n_rst low: all state clears immediately, no clock needed.
//   - Cleared state: shift reg=0, bit_cnt=0, state=S_DATA.
//   - Cleared outputs: dout_valid=0, dout_data=0, dout_perr=0, overrun=0.
//   - Reset mid-word discards the partial word; no output is produced.
//  Shift path:
//   - On each cycle with din_valid=1 in S_DATA: sh <= {din_d, sh[WIDTH-1:1]}
//     and bit_cnt increments.
//   - Cycles with din_valid=0 hold all state; gaps are allowed anywhere.
//  Word completion:
//   - Occurs on the valid bit with bit_cnt==WIDTH-1 (in S_DATA without
//     SIPO_PARITY_EN, in S_PAR with it).
//   - bit_cnt wraps to 0 and the FSM returns to S_DATA.
//  Latency: word is visible on dout_data/dout_valid the cycle after its last
//   bit is sampled.
//  Output register (1 deep):
//   - Loads on completion if dout_valid=0 or dout_ready=1 in that same cycle;
//     dout_valid<=1.
//   - Simultaneous accept+complete: the new word replaces the old one and
//     dout_valid stays 1 with no gap.
//   - Accept without completion: dout_valid<=0; dout_data holds its value.
//   - Completion while dout_valid=1 and dout_ready=0: the new word is dropped,
//     the old word is kept, and overrun=1 for exactly one cycle.
//   - dout_data/dout_perr remain stable while dout_valid=1 and dout_ready=0.
//  FSM: S_DATA, S_PAR. S_PAR exists only with the macro.
//   - S_DATA -> S_PAR after the WIDTH-th data bit.
//   - S_PAR -> S_DATA after the parity bit.
// CONFIGURATION
//  SIPO_PARITY_EN defined:
//   - Each word is followed by one even-parity bit; a word spans WIDTH+1
//     valid bits.
//   - Completion occurs on the parity bit.
//   - dout_perr = (parity bit != ^data), loaded together with dout_data.
//  SIPO_PARITY_EN undefined:
//   - No S_PAR state; a word is WIDTH bits.
//   - dout_perr is tied to 0.
// STRUCTURE
//  Package sipo_pkg:
//   - state enum (S_DATA, S_PAR)
//   - default WIDTH constant
//   - function clog2 for CNT_W
//  Sub-module sipo_outreg: 1-deep valid/ready output register with overrun
//   detection. Shift/count/FSM logic lives in the top level.
// TESTING (WIDTH=8)
//  1. Reset: n_rst low asynchronously between edges -> all outputs 0 before
//     the next edge; release at 22 ns.
//  2. Basic: bits 1,0,1,1,0,0,1,0 back-to-back, dout_ready=1 ->
//     dout_data=8'h4D, dout_valid for 1 cycle, 1 cycle after the last bit.
//  3. Gaps: same bits with din_valid low every other cycle -> same 8'h4D,
//     with no extra words.
//  4. Backpressure: dout_ready=0 across two full words (8'hA5, 8'h3C) ->
//     dout_data stays 8'hA5, one overrun pulse; then ready=1 -> valid drops.
//  5. Simultaneous: ready=1 on the exact cycle word 2 completes -> valid
//     stays high and data changes 8'hA5 -> 8'h3C with no overrun.
//  6. Mid-word reset: after 5 bits, pulse n_rst; then 8 bits of 8'hFF ->
//     output is 8'hFF. With SIPO_PARITY_EN: 8'h4D + parity 0 -> perr=0;
//     parity 1 -> perr=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, default width and clog2 helper for sipo_deser
package sipo_pkg;

   typedef enum logic {
      S_DATA = 1'b0,
      S_PAR  = 1'b1
   } state_t;

   localparam int SIPO_WIDTH = 8;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << result) < value) result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sipo_outreg.sv
// rtl/sipo_outreg.sv - 1-deep valid/ready output register with overrun pulse
module sipo_outreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_perr,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             perr,
   output logic             overrun
);

   logic can_load;

   // A held word may be replaced in the same cycle it is accepted.
   assign can_load = !valid || ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         valid   <= 1'b0;
         data    <= '0;
         perr    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load && can_load) begin
            valid <= 1'b1;
            data  <= load_data;
            perr  <= load_perr;
         end else if (load) begin
            overrun <= 1'b1;
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - LSB-first serial-to-parallel deserializer
// Optional even-parity trailer bit enabled by SIPO_PARITY_EN.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_WIDTH,
   parameter int CNT_W = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             din_valid,
   input  logic             din_d,
   input  logic             dout_ready,
   output logic             dout_valid,
   output logic [WIDTH-1:0] dout_data,
   output logic             dout_perr,
   output logic             overrun
);

   if (WIDTH < 2 || CNT_W != clog2(WIDTH)) begin : g_bad_param
      $error("sipo_deser: WIDTH must be >= 2 and CNT_W must equal clog2(WIDTH)");
   end

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh;
   logic [CNT_W-1:0] bit_cnt;
   logic             last_bit;
   logic             shift_en;
   logic             cnt_inc;
   logic             cnt_clr;
   logic             complete;
   logic [WIDTH-1:0] word;
   logic             word_perr;

   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_DATA;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
`ifdef SIPO_PARITY_EN
      case (state)
         S_DATA:  if (din_valid && last_bit) state_nxt = S_PAR;
         S_PAR:   if (din_valid) state_nxt = S_DATA;
         default: state_nxt = S_DATA;
      endcase
`else
      state_nxt = S_DATA;
`endif
   end

   // The counter parks at WIDTH-1 while the parity bit is awaited.
   always_comb begin
      shift_en = 1'b0;
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      complete = 1'b0;
      case (state)
         S_DATA: begin
            shift_en = din_valid;
            cnt_inc  = din_valid && !last_bit;
`ifndef SIPO_PARITY_EN
            cnt_clr  = din_valid && last_bit;
            complete = din_valid && last_bit;
`endif
         end
`ifdef SIPO_PARITY_EN
         S_PAR: begin
            cnt_clr  = din_valid;
            complete = din_valid;
         end
`endif
         default: ;
      endcase
   end

`ifdef SIPO_PARITY_EN
   assign word      = sh;
   assign word_perr = din_d ^ (^sh);
`else
   assign word      = {din_d, sh[WIDTH-1:1]};
   assign word_perr = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sh      <= '0;
         bit_cnt <= '0;
      end else begin
         if (shift_en) sh <= {din_d, sh[WIDTH-1:1]};
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   sipo_outreg #(
      .WIDTH(WIDTH)
   ) u_outreg (
      .clk       (clk),
      .n_rst     (n_rst),
      .load      (complete),
      .load_data (word),
      .load_perr (word_perr),
      .ready     (dout_ready),
      .valid     (dout_valid),
      .data      (dout_data),
      .perr      (dout_perr),
      .overrun   (overrun)
   );

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - randomized and directed bench for sipo_deser against a bit-queue model
module tb_sipo_deser;

   localparam int W = 8;
`ifdef SIPO_PARITY_EN
   localparam int WORD_BITS = W + 1;
`else
   localparam int WORD_BITS = W;
`endif

   logic         clk;
   logic         n_rst;
   logic         din_valid;
   logic         din_d;
   logic         dout_ready;
   logic         dout_valid;
   logic [W-1:0] dout_data;
   logic         dout_perr;
   logic         overrun;

   int errors = 0;
   int checks = 0;
   int ovr_seen = 0;

   logic         q[$];
   logic         mv;
   logic [W-1:0] md;
   logic         mp;
   logic         mo;

   sipo_deser #(
      .WIDTH(W)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .din_valid  (din_valid),
      .din_d      (din_d),
      .dout_ready (dout_ready),
      .dout_valid (dout_valid),
      .dout_data  (dout_data),
      .dout_perr  (dout_perr),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mv = 1'b0;
      md = '0;
      mp = 1'b0;
      mo = 1'b0;
   endtask

   // Words are whatever WORD_BITS valid bits have accumulated, LSB first.
   task automatic model_edge(input logic v, input logic d, input logic r);
      logic         done;
      logic [W-1:0] w;
      logic         pe;
      done = 1'b0;
      w    = '0;
      pe   = 1'b0;
      if (v) begin
         q.push_back(d);
         if (q.size() == WORD_BITS) begin
            for (int i = 0; i < W; i++) if (q[i]) w = w + (W'(1) << i);
            if (WORD_BITS > W) pe = (q[W] != (^w));
            q.delete();
            done = 1'b1;
         end
      end
      mo = 1'b0;
      if (done) begin
         if (!mv || r) begin
            mv = 1'b1;
            md = w;
            mp = pe;
         end else begin
            mo = 1'b1;
         end
      end else if (r) begin
         mv = 1'b0;
      end
   endtask

   task automatic step(input logic v, input logic d, input logic r);
      din_valid  = v;
      din_d      = d;
      dout_ready = r;
      @(posedge clk);
      model_edge(v, d, r);
      #2;
      if (overrun === 1'b1) ovr_seen++;
      chk("valid", dout_valid, mv);
      chk("data", dout_data, md);
      chk("perr", dout_perr, mp);
      chk("overrun", overrun, mo);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic par_flip, input logic gaps,
                            input logic r, input logic r_last);
      for (int i = 0; i < W; i++) begin
         if (gaps) step(1'b0, 1'($urandom), r);
         step(1'b1, w[i], (i == W - 1 && WORD_BITS == W) ? r_last : r);
      end
`ifdef SIPO_PARITY_EN
      if (gaps) step(1'b0, 1'($urandom), r);
      step(1'b1, (^w) ^ par_flip, r_last);
`else
      if (par_flip) step(1'b0, 1'b0, r);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, dout_valid, 32'd0);
      chk({tag, "_data"}, dout_data, 32'd0);
      chk({tag, "_perr"}, dout_perr, 32'd0);
      chk({tag, "_overrun"}, overrun, 32'd0);
   endtask

   initial begin
      int ovr_base;
      n_rst      = 1'b0;
      din_valid  = 1'b0;
      din_d      = 1'b0;
      dout_ready = 1'b0;
      model_reset();
      #3;
      check_reset_outputs("reset");
      #19;
      n_rst = 1'b1;

      // basic word, ready held high
      send_word(8'h4D, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("basic_word", dout_data, 32'h4D);
      chk("basic_valid", dout_valid, 32'd1);
      step(1'b0, 1'b0, 1'b1);
      chk("basic_drop", dout_valid, 32'd0);

      // same word with gaps
      send_word(8'h4D, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("gap_word", dout_data, 32'h4D);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
      chk("gap_no_extra", dout_valid, 32'd0);

      // backpressure across two words
      ovr_base = ovr_seen;
      send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_hold", dout_data, 32'hA5);
      chk("bp_ovr_count", 32'(ovr_seen - ovr_base), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      chk("bp_release", dout_valid, 32'd0);

      // accept on the exact completion cycle of word 2
      ovr_base = ovr_seen;
      send_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sim_first", dout_data, 32'hA5);
      send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("sim_second", dout_data, 32'h3C);
      chk("sim_valid", dout_valid, 32'd1);
      chk("sim_no_ovr", 32'(ovr_seen - ovr_base), 32'd0);

      // mid-word reset with a word still held
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      n_rst = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("async_rst");
      #1;
      n_rst = 1'b1;
      send_word(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst_word", dout_data, 32'hFF);
      chk("rst_valid", dout_valid, 32'd1);

`ifdef SIPO_PARITY_EN
      send_word(8'h4D, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("par_ok", dout_perr, 32'd0);
      send_word(8'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("par_bad", dout_perr, 32'd1);
      chk("par_data", dout_data, 32'h4D);
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
